// File: rtl/board_sysctl_if.sv
// board_sysctl_if: board-side signals of the system controller.
// The controller takes the slave view; the board top (or a bench) takes master.
interface board_sysctl_if #(
  parameter int NUM_LEDS = 8
);
  logic                pll_locked;
  logic                btn_n;
  logic [1:0]          mode;
  logic                sys_reset;
  logic                sys_ready;
  logic [NUM_LEDS-1:0] led;

  modport master (
    output pll_locked, btn_n, mode,
    input  sys_reset, sys_ready, led
  );

  modport slave (
    input  pll_locked, btn_n, mode,
    output sys_reset, sys_ready, led
  );
endinterface

// File: rtl/board_sysctl.sv
// board_sysctl: synchronises PLL lock and the reset button, sequences a
// stretched synchronous reset for downstream logic and drives an LED bank
// from an exact-period heartbeat in one of four display modes.
module board_sysctl #(
  parameter int LOCK_SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYCLES   = 1_250_000,
  parameter int RESET_HOLD_CYCLES = 1024,
  parameter int HEARTBEAT_DIV     = 62_500_000,
  parameter int NUM_LEDS          = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  board_sysctl_if.slave bus
);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int HB_W   = $clog2(HEARTBEAT_DIV);
  localparam int POS_W  = $clog2(NUM_LEDS);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  // ---------------------------------------------------------------- sync
  logic [LOCK_SYNC_STAGES-1:0] lock_sync_q;
  logic [LOCK_SYNC_STAGES-1:0] btn_sync_q;
  logic                        lock_s;
  logic                        btn_s;

  // Metastability chains; the button idles released (high).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_sync_q <= '0;
      btn_sync_q  <= '1;
    end else begin
      lock_sync_q <= {lock_sync_q[LOCK_SYNC_STAGES-2:0], bus.pll_locked};
      btn_sync_q  <= {btn_sync_q[LOCK_SYNC_STAGES-2:0], bus.btn_n};
    end
  end

  assign lock_s = lock_sync_q[LOCK_SYNC_STAGES-1];
  assign btn_s  = btn_sync_q[LOCK_SYNC_STAGES-1];

  // ------------------------------------------------------------ debounce
  logic            btn_db_q, btn_db_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            press_q, press_d;

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing
  // samples; press fires once, in the cycle the debounced level first reads 0.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = db_cnt_q;
    press_d  = 1'b0;
    if (btn_s == btn_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      btn_db_d = btn_s;
      db_cnt_d = '0;
      press_d  = ~btn_s;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Debounce state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_db_q <= 1'b1;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
    end else begin
      btn_db_q <= btn_db_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
    end
  end

  // ----------------------------------------------------------- reset FSM
  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  // Lock loss beats a press; a press while waiting for lock is ignored.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (press_q) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_W'(RESET_HOLD_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (press_q) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = WAIT_LOCK;
        hold_cnt_d = '0;
      end
    endcase
  end

  // Reset sequencer state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= WAIT_LOCK;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Decoded straight from the state register so downstream sees no glitches.
  logic run;
  assign run           = (state_q == RUN);
  assign bus.sys_reset = ~run;
  assign bus.sys_ready = run;

  // ----------------------------------------------------------- heartbeat
  logic [HB_W-1:0] hb_cnt_q;
  logic            tick;
  logic            hb_q;

  assign tick = (hb_cnt_q == HB_W'(HEARTBEAT_DIV - 1));

  // Divider wraps at DIV-1 so the tick period is exactly HEARTBEAT_DIV.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else if (tick) begin
      hb_cnt_q <= '0;
      hb_q     <= ~hb_q;
    end else begin
      hb_cnt_q <= hb_cnt_q + HB_W'(1);
    end
  end

  // ------------------------------------------------------------ patterns
  logic [NUM_LEDS-1:0] bin_cnt_q;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                dir_up_q, dir_up_d;

  // Scanner bounces off both ends: at an end it turns and steps inward.
  always_comb begin
    pos_d    = pos_q;
    dir_up_d = dir_up_q;
    if (dir_up_q) begin
      if (pos_q == POS_W'(NUM_LEDS - 1)) begin
        dir_up_d = 1'b0;
        pos_d    = pos_q - POS_W'(1);
      end else begin
        pos_d = pos_q + POS_W'(1);
      end
    end else begin
      if (pos_q == '0) begin
        dir_up_d = 1'b1;
        pos_d    = POS_W'(1);
      end else begin
        pos_d = pos_q - POS_W'(1);
      end
    end
  end

  // Patterns advance on every tick whatever the mode, so switching is seamless.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bin_cnt_q <= '0;
      pos_q     <= '0;
      dir_up_q  <= 1'b1;
    end else if (tick) begin
      bin_cnt_q <= bin_cnt_q + NUM_LEDS'(1);
      pos_q     <= pos_d;
      dir_up_q  <= dir_up_d;
    end
  end

  // ----------------------------------------------------------------- LEDs
  logic [NUM_LEDS-1:0] led_q, led_d;

  // Select the display for the current mode; registered below.
  always_comb begin
    led_d = '0;
    case (bus.mode)
      2'd0: led_d = {NUM_LEDS{hb_q}};
      2'd1: led_d = bin_cnt_q;
      2'd2: led_d = NUM_LEDS'(1) << pos_q;
      default: begin
        led_d[0] = hb_q;
        led_d[1] = lock_s;
        led_d[2] = run;
      end
    endcase
  end

  // LED output register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) led_q <= '0;
    else          led_q <= led_d;
  end

  assign bus.led = led_q;

endmodule

// File: doc/board_sysctl.md
# board_sysctl

Board-level system controller for the ULX3S build: replaces the ad-hoc lock synchroniser and fixed-period LED blinker in the top level with one parametrised block. It synchronises the PLL lock and a raw reset button, sequences a stretched synchronous reset for downstream logic (e.g. `Raster`), and drives a configurable-width LED bank in one of four display modes from an exact-period heartbeat. Sits in the PLL output clock domain, directly below `top`.

## Interface

- `LOCK_SYNC_STAGES`, 2: synchroniser depth for `pll_locked` and `btn_n` (>=2).
- `DEBOUNCE_CYCLES`, 1_250_000: consecutive stable samples required to accept a new button level (>=2).
- `RESET_HOLD_CYCLES`, 1024: cycles `sys_reset` stays high after lock/press (>=1).
- `HEARTBEAT_DIV`, 62_500_000: clocks per heartbeat tick (>=2).
- `NUM_LEDS`, 8: LED bank width (>=3).

- `clock`  in  1  system clock (PLL output); all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset; one clock, reset asynchronous active-low.
- `pll_locked`  in  1  PLL lock, asynchronous to `clock`.
- `btn_n`  in  1  raw reset button, active-low, asynchronous, bouncy.
- `mode`  in  2  LED display mode, quasi-static.
- `sys_reset`  out  1  active-high synchronous reset for downstream logic.
- `sys_ready`  out  1  high when downstream logic is out of reset.
- `led`  out  NUM_LEDS  LED drive, active-high.

## Operation

- Sync: `pll_locked` and `btn_n` each pass through `LOCK_SYNC_STAGES` flops -> `lock_s`, `btn_s`. Reset values: lock chain 0, button chain 1.
- Debounce: register `btn_db` (reset 1), counter `db_cnt` (reset 0). If `btn_s == btn_db`: `db_cnt <= 0`. Else if `db_cnt == DEBOUNCE_CYCLES-1`: `btn_db <= btn_s`, `db_cnt <= 0`. Else `db_cnt++`. `press` = single-cycle pulse on `btn_db` 1->0.
- Reset FSM, states WAIT_LOCK (reset state), HOLD, RUN; counter `hold_cnt`:
  - WAIT_LOCK: `lock_s`=1 -> HOLD, `hold_cnt <= 0`.
  - HOLD: `lock_s`=0 -> WAIT_LOCK; else `press` -> `hold_cnt <= 0`, stay; else `hold_cnt == RESET_HOLD_CYCLES-1` -> RUN; else `hold_cnt++`.
  - RUN: `lock_s`=0 -> WAIT_LOCK; else `press` -> HOLD, `hold_cnt <= 0`.
  - Lock loss has priority over `press` in the same cycle. `press` in WAIT_LOCK is ignored.
- `sys_reset = (state != RUN)`, `sys_ready = (state == RUN)`, decoded from the state register only (glitch-free, registered state).
- Heartbeat: `hb_cnt` counts 0..HEARTBEAT_DIV-1 and wraps. `tick` is high for one cycle when `hb_cnt == HEARTBEAT_DIV-1`. Exact period HEARTBEAT_DIV, not DIV+1. `hb` (reset 0) toggles on each `tick`. Runs in every FSM state.
- Pattern registers update on `tick` regardless of `mode`, so mode switches are seamless:
  - `bin_cnt` (NUM_LEDS bits, reset 0): +1 per tick, wraps modulo 2^NUM_LEDS.
  - Scanner `pos` (reset 0) and `dir` (reset up). Per tick, `pos` moves one step. At `pos == NUM_LEDS-1` going up, or at 0 going down, `dir` flips and `pos` moves the other way. Sequence for 4 LEDs: 0,1,2,3,2,1,0,1...
- `led` register (reset all 0), loaded every cycle from the current `mode` and pattern state:
  - mode 0: all bits = `hb`.
  - mode 1: `bin_cnt`.
  - mode 2: one-hot at `pos`.
  - mode 3: status. `led[0]=hb`, `led[1]=lock_s`, `led[2]=sys_ready`, other bits 0.

## Timing

- During and immediately after `reset_n` low, all outputs are low except `sys_reset`, which is 1. State is WAIT_LOCK.
- `pll_locked` rise -> `lock_s` high after `LOCK_SYNC_STAGES` edges. One edge later, state = HOLD. `sys_ready` rises exactly `RESET_HOLD_CYCLES` edges after entering HOLD.
- `pll_locked` fall -> `sys_reset` high `LOCK_SYNC_STAGES+1` edges later.
- Button: stable low for `DEBOUNCE_CYCLES` synced samples -> `press`. The next edge enters HOLD. Bounces shorter than `DEBOUNCE_CYCLES` produce no event. Holding the button produces one event only.
- `led` lags pattern state and `mode` by one cycle.
- `reset_n` assertion mid-HOLD or mid-debounce clears every counter immediately (asynchronously).

## Test plan

All scenarios use `LOCK_SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `RESET_HOLD_CYCLES`=8, `HEARTBEAT_DIV`=4, `NUM_LEDS`=4.

- Lock bring-up: release `reset_n` with `pll_locked`=1 -> `sys_reset` stays 1 through edge 10, `sys_ready` = 1 from edge 11 onward. Drop `pll_locked` -> `sys_reset` = 1 three edges later.
- Debounce: pulse `btn_n` low for 3 cycles, 5 times -> no HOLD re-entry. Hold `btn_n` low for 20 cycles -> exactly one HOLD of 8 cycles, then RUN while still pressed.
- Press during HOLD at `hold_cnt`=5 -> count restarts; `sys_ready` rises 8 edges after the press. Lock loss coincident with `press` -> WAIT_LOCK.
- Heartbeat: mode 0 -> `led` toggles between 0000 and 1111 every 4 cycles (period 8). mode 1 -> 0000,0001,...,1111,0000 at one step per 4 cycles.
- Scanner: mode 2 -> one-hot sequence 0001,0010,0100,1000,0100,0010,0001,0010. Switching to mode 3 and back mid-sequence resumes at the correct position.
- Async reset mid-operation: assert `reset_n` in RUN with `bin_cnt`=0101 -> `led`=0000 and `sys_reset`=1 with no clock edge; after release the full sequence restarts from WAIT_LOCK.
